// File: rtl/cle_seq_unlock.sv
// Bus-snooping key-sequence unlock detector for the card-select window.
// Optional lockout after repeated bad keys: define CLE_LOCKOUT_EN.
module cle_seq_unlock #(
  parameter int                     ADDR_W   = 14,
  parameter logic [1:0]             WIN      = 2'b01,
  parameter int                     KEY_LSB  = 4,
  parameter int                     KEY_W    = 4,
  parameter int                     DEPTH    = 4,
  parameter logic [DEPTH*KEY_W-1:0] KEYS     = 16'h5A3C,
  parameter logic [7:0]             STAT     = 8'hA5,
  parameter int                     MAX_FAIL = 3,
  parameter int                     LOCK_ACC = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sser_n,
  input  logic [ADDR_W-1:0] ba,
  input  logic              br_w,
  input  logic              oe_n,
  output logic [3:0]        st_n,
  output logic              st_oe,
  output logic              sdrd,
  output logic              sdrd_oe,
  output logic              unlocked
);

  localparam int SW = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEQ  = 2'd1,
    UNLK = 2'd2,
    LOCK = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   step_q, step_d;
  logic            hit, hit_q, acc;
  logic [KEY_W-1:0] kf, cur_key, key0, klast;
  logic            last;
  logic [1:0]      code;
  logic            lock;
  logic            unused_ok;

`ifdef CLE_LOCKOUT_EN
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam int LW = $clog2(LOCK_ACC + 1);
  logic [FW-1:0] fail_q, fail_d;
  logic [LW-1:0] lcnt_q, lcnt_d;
`endif

  assign hit = ~sser_n & (ba[ADDR_W-1:ADDR_W-2] == WIN) & br_w;
  assign acc = hit & ~hit_q;
  assign kf  = ba[KEY_LSB+KEY_W-1:KEY_LSB];
  assign key0  = KEYS[KEY_W-1:0];
  assign klast = KEYS[(DEPTH-1)*KEY_W +: KEY_W];
  assign last  = (step_q == SW'(DEPTH - 1));
  assign unused_ok = ^{ba, 32'(MAX_FAIL), 32'(LOCK_ACC)};

  always_comb begin
    cur_key = key0;
    for (int i = 0; i < DEPTH; i++)
      if (step_q == SW'(i)) cur_key = KEYS[i*KEY_W +: KEY_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= '0;
      hit_q   <= 1'b0;
`ifdef CLE_LOCKOUT_EN
      fail_q  <= '0;
      lcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      hit_q   <= hit;
`ifdef CLE_LOCKOUT_EN
      fail_q  <= fail_d;
      lcnt_q  <= lcnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
`ifdef CLE_LOCKOUT_EN
    fail_d  = fail_q;
    lcnt_d  = lcnt_q;
`endif
    if (acc) begin
      unique case (state_q)
        IDLE, SEQ: begin
          if (kf == cur_key) begin
            if (last) begin
              state_d = UNLK;
              step_d  = '0;
`ifdef CLE_LOCKOUT_EN
              fail_d  = '0;
`endif
            end else begin
              state_d = SEQ;
              step_d  = step_q + SW'(1);
            end
          end else if (kf == key0) begin
            state_d = SEQ;
            step_d  = SW'(1);
          end else begin
            state_d = IDLE;
            step_d  = '0;
`ifdef CLE_LOCKOUT_EN
            fail_d  = fail_q + FW'(1);
            if (fail_q == FW'(MAX_FAIL - 1)) begin
              state_d = LOCK;
              lcnt_d  = LW'(LOCK_ACC);
            end
`endif
          end
        end
        UNLK: begin
          if (kf == klast) state_d = IDLE;
        end
        LOCK: begin
`ifdef CLE_LOCKOUT_EN
          // keys are ignored; only the access count matters here
          if (lcnt_q <= LW'(1)) begin
            state_d = IDLE;
            lcnt_d  = '0;
            fail_d  = '0;
          end else begin
            lcnt_d  = lcnt_q - LW'(1);
          end
`else
          state_d = IDLE;
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign unlocked = (state_q == UNLK);
  assign lock     = (state_q == LOCK);
  assign code     = (step_q > SW'(3)) ? 2'd3 : step_q[1:0];
  assign st_n     = ~{unlocked, lock, code};
  assign st_oe    = ~oe_n;
  assign sdrd     = STAT[step_q];
  assign sdrd_oe  = hit & ~unlocked;

endmodule

// File: tb/tb_cle_seq_unlock.sv
// Directed bench for cle_seq_unlock, default parameters.
// Lockout steps compile in only with CLE_LOCKOUT_EN.
module tb_cle_seq_unlock;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sser_n;
  logic [13:0] ba;
  logic        br_w;
  logic        oe_n;
  logic [3:0]  st_n;
  logic        st_oe;
  logic        sdrd;
  logic        sdrd_oe;
  logic        unlocked;

  int ntot  = 0;
  int npass = 0;

  cle_seq_unlock dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sser_n   (sser_n),
    .ba       (ba),
    .br_w     (br_w),
    .oe_n     (oe_n),
    .st_n     (st_n),
    .st_oe    (st_oe),
    .sdrd     (sdrd),
    .sdrd_oe  (sdrd_oe),
    .unlocked (unlocked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    ntot++;
    assert (got === exp) npass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic bus(input logic s_n, input logic [1:0] w,
                     input logic rd, input logic [3:0] k,
                     input int hold, input logic eoe,
                     input logic esd);
    sser_n = s_n;
    br_w   = rd;
    ba     = {w, 4'h0, k, 4'h0};
    #1;
    chk("sdrd_oe", {7'd0, sdrd_oe}, {7'd0, eoe});
    chk("sdrd", {7'd0, sdrd}, {7'd0, esd});
    repeat (hold) @(posedge clk);
    #1;
    sser_n = 1'b1;
    br_w   = 1'b0;
    ba     = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [3:0] k, input logic eoe,
                     input logic esd);
    bus(1'b0, 2'b01, 1'b1, k, 1, eoe, esd);
  endtask

  task automatic st(input string tag, input logic [3:0] e);
    chk(tag, {4'd0, st_n}, {4'd0, e});
  endtask

  initial begin
    rst_n  = 1'b0;
    sser_n = 1'b1;
    br_w   = 1'b0;
    ba     = '0;
    oe_n   = 1'b0;
    #3;
    st("rst_st", 4'hF);
    chk("rst_unl", {7'd0, unlocked}, 8'd0);
    chk("rst_sdrd", {7'd0, sdrd}, 8'd1);
    chk("rst_st_oe", {7'd0, st_oe}, 8'd1);
    chk("rst_sdrd_oe", {7'd0, sdrd_oe}, 8'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    key(4'hC, 1'b1, 1'b1);
    st("mid_s1", 4'hE);
    key(4'h3, 1'b1, 1'b0);
    st("mid_s2", 4'hD);
    rst_n = 1'b0;
    #1;
    st("mid_rst_st", 4'hF);
    chk("mid_rst_unl", {7'd0, unlocked}, 8'd0);
    oe_n = 1'b1;
    #1;
    chk("oe_off", {7'd0, st_oe}, 8'd0);
    oe_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    key(4'hC, 1'b1, 1'b1);
    st("seq_s1", 4'hE);
    key(4'h3, 1'b1, 1'b0);
    st("seq_s2", 4'hD);
    key(4'hA, 1'b1, 1'b1);
    st("seq_s3", 4'hC);
    key(4'h5, 1'b1, 1'b0);
    st("seq_unl_st", 4'h7);
    chk("seq_unl", {7'd0, unlocked}, 8'd1);

    key(4'hA, 1'b0, 1'b1);
    st("unl_ignore", 4'h7);
    key(4'h5, 1'b0, 1'b1);
    st("relock_st", 4'hF);
    chk("relock_unl", {7'd0, unlocked}, 8'd0);

    bus(1'b0, 2'b01, 1'b1, 4'hC, 5, 1'b1, 1'b1);
    st("held_c", 4'hE);
    bus(1'b0, 2'b01, 1'b1, 4'h3, 3, 1'b1, 1'b0);
    st("held_3", 4'hD);

    bus(1'b0, 2'b10, 1'b1, 4'hA, 1, 1'b0, 1'b1);
    st("nh_win", 4'hD);
    bus(1'b0, 2'b01, 1'b0, 4'hA, 1, 1'b0, 1'b1);
    st("nh_rd", 4'hD);
    bus(1'b1, 2'b01, 1'b1, 4'hA, 1, 1'b0, 1'b1);
    st("nh_sel", 4'hD);

    key(4'h7, 1'b1, 1'b1);
    st("bad_s2", 4'hF);
    key(4'hC, 1'b1, 1'b1);
    key(4'h3, 1'b1, 1'b0);
    st("re_s2", 4'hD);
    key(4'hC, 1'b1, 1'b1);
    st("restart", 4'hE);
    key(4'h3, 1'b1, 1'b0);
    key(4'hA, 1'b1, 1'b1);
    key(4'h5, 1'b1, 1'b0);
    st("unl2", 4'h7);
    key(4'h5, 1'b0, 1'b1);
    st("relock2", 4'hF);

    key(4'h1, 1'b1, 1'b1);
    st("bad_idle1", 4'hF);
    key(4'h2, 1'b1, 1'b1);
    st("bad_idle2", 4'hF);
    key(4'h7, 1'b1, 1'b1);
`ifdef CLE_LOCKOUT_EN
    st("lock_in", 4'hB);
    key(4'hC, 1'b1, 1'b1);
    key(4'h3, 1'b1, 1'b1);
    key(4'hA, 1'b1, 1'b1);
    key(4'h5, 1'b1, 1'b1);
    st("lock_keys", 4'hB);
    chk("lock_unl", {7'd0, unlocked}, 8'd0);
    for (int i = 0; i < 10; i++) key(4'hC, 1'b1, 1'b1);
    st("lock_14", 4'hB);
    key(4'h0, 1'b1, 1'b1);
    st("lock_out", 4'hF);
`else
    st("bad_idle3", 4'hF);
`endif
    key(4'hC, 1'b1, 1'b1);
    key(4'h3, 1'b1, 1'b0);
    key(4'hA, 1'b1, 1'b1);
    key(4'h5, 1'b1, 1'b0);
    st("final_unl", 4'h7);
    chk("final_unl_f", {7'd0, unlocked}, 8'd1);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
